// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//
// Valid/ready FIFO sitting directly in front of the data consumer stage.
// It absorbs producer bursts while the consumer stalls, presents the head
// word first-word-fall-through, reports its fill level and supports a
// synchronous flush. Single clock domain.
//
// Parameters
//   WIDTH   data width in bits (must match the downstream stage)
//   DEPTH   number of entries, power of two, >= 2
//
// Ports
//   clk_i      clock, all state updates on the rising edge
//   rst_ni     asynchronous active-low reset
//   flush_i    synchronous flush, discards every stored entry
//   s_valid_i  upstream word valid
//   s_ready_o  FIFO can accept a word this cycle (registered)
//   s_data_i   upstream data
//   m_valid_o  m_data_o holds a valid word (registered)
//   m_ready_i  downstream accepts the head word this cycle
//   m_data_o   head-of-FIFO data, all zeros while m_valid_o is low
//   level_o    number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [WIDTH-1:0]           s_data_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [WIDTH-1:0]           m_data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic             s_ready;
    logic             m_valid;
    logic             push;
    logic             pop;

    // Handshakes are qualified by the registered status flags, so a push can
    // never land in a full FIFO and a pop can never drain an empty one.
    always_comb begin
        push       = s_valid_i & s_ready;
        pop        = m_valid & m_ready_i;
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Control state: pointers, level counter and the status flags. The flags
    // are computed from level_next so they are already correct in the cycle
    // after the handshake, with no combinational path from the inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level   <= level_next;
            s_ready <= (level_next < LW'(DEPTH));
            m_valid <= (level_next != '0);
        end
    end

    // Storage is not reset. A push in a flush cycle is dropped so the word
    // cannot reappear later through a stale slot.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

    // While stalled rd_ptr is frozen and wr_ptr can only equal rd_ptr when the
    // FIFO is full (no push), so the head word stays stable.
    assign m_data_o  = m_valid ? mem[rd_ptr] : '0;
    assign m_valid_o = m_valid;
    assign s_ready_o = s_ready;
    assign level_o   = level;

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [LW-1:0]    level;

    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of stored words plus the "can accept" flag,
    // which is low while in reset and until the first edge after release.
    logic [WIDTH-1:0] q[$];
    logic             mdl_ready;
    logic [WIDTH-1:0] popped[$];

    logic             exp_v;
    logic             exp_r;
    logic [LW-1:0]    exp_l;
    logic [WIDTH-1:0] exp_d;

    task automatic calc_exp();
        exp_v = (q.size() != 0);
        exp_r = mdl_ready;
        exp_l = LW'(q.size());
        exp_d = (q.size() != 0) ? q[0] : '0;
    endtask

    // Drive inputs (called just after a falling edge), advance one rising
    // edge while updating the model, and return at the next falling edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                         input logic mr, input logic fl);
        logic do_push;
        logic do_pop;
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        flush   = fl;
        do_push = v && mdl_ready;
        do_pop  = mr && (q.size() != 0);
        if (do_pop && !fl) popped.push_back(m_data);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mdl_ready = 1'b0;
        end else if (fl) begin
            q.delete();
            mdl_ready = 1'b1;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
            mdl_ready = (q.size() < DEPTH);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q.delete();
        mdl_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            calc_exp();
            tests++;
            if (m_valid !== exp_v || s_ready !== exp_r || level !== exp_l || m_data !== exp_d) begin
                fails++;
                $display("FAIL reset cyc%0d: got v=%b r=%b lvl=%0d d=%h, want v=%b r=%b lvl=%0d d=%h",
                         i, m_valid, s_ready, level, m_data, exp_v, exp_r, exp_l, exp_d);
            end
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_no_edge: got s_ready=%b, want 0", s_ready);
        end
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b0);
        tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== '0) begin
            fails++;
            $display("FAIL reset_release_edge: got r=%b v=%b lvl=%0d, want r=1 v=0 lvl=0",
                     s_ready, m_valid, level);
        end
    endtask

    task automatic test_fall_through();
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (m_valid !== 1'b1 || m_data !== 32'hDEADBEEF || level !== LW'(1)) begin
                fails++;
                $display("FAIL fall_through cyc%0d: got v=%b d=%h lvl=%0d, want v=1 d=deadbeef lvl=1",
                         i, m_valid, m_data, level);
            end
            if (i < 5) cycle(1'b0, $urandom, 1'b0, 1'b0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        calc_exp();
        tests++;
        if (m_valid !== exp_v || s_ready !== exp_r || level !== exp_l || m_data !== exp_d) begin
            fails++;
            $display("FAIL fall_through_drain: got v=%b r=%b lvl=%0d d=%h, want v=%b r=%b lvl=%0d d=%h",
                     m_valid, s_ready, level, m_data, exp_v, exp_r, exp_l, exp_d);
        end
    endtask

    task automatic test_fill_full();
        logic [WIDTH-1:0] want[$];
        want = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        popped.delete();
        for (int i = 1; i <= 4; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        // 0x5 is held on the input while full, then one pop frees a slot.
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (level !== LW'(DEPTH) || s_ready !== 1'b0 || m_data !== 32'h1) begin
                fails++;
                $display("FAIL full_hold cyc%0d: got lvl=%0d r=%b d=%h, want lvl=%0d r=0 d=1",
                         i, level, s_ready, m_data, DEPTH);
            end
            cycle(1'b1, 32'h5, (i == 3), 1'b0);
        end
        tests++;
        if (level !== LW'(3) || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_pop_reopen: got lvl=%0d r=%b, want lvl=3 r=1", level, s_ready);
        end
        cycle(1'b1, 32'h5, 1'b0, 1'b0);
        tests++;
        if (level !== LW'(4) || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_accept5: got lvl=%0d r=%b, want lvl=4 r=0", level, s_ready);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            calc_exp();
            tests++;
            if (m_valid !== exp_v || s_ready !== exp_r || level !== exp_l || m_data !== exp_d) begin
                fails++;
                $display("FAIL fill_drain cyc%0d: got v=%b r=%b lvl=%0d d=%h, want v=%b r=%b lvl=%0d d=%h",
                         i, m_valid, s_ready, level, m_data, exp_v, exp_r, exp_l, exp_d);
            end
        end
        tests++;
        if (popped.size() != 5 || popped != want) begin
            fails++;
            $display("FAIL fill_order: got %0d words %p, want %p", popped.size(), popped, want);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
            tests++;
            if (m_valid !== 1'b1 || level !== LW'(1) || m_data !== WIDTH'(i) || s_ready !== 1'b1) begin
                fails++;
                $display("FAIL wrap cyc%0d: got v=%b lvl=%0d d=%h r=%b, want v=1 lvl=1 d=%h r=1",
                         i, m_valid, level, m_data, s_ready, WIDTH'(i));
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        tests++;
        if (m_valid !== 1'b0 || level !== '0) begin
            fails++;
            $display("FAIL wrap_empty: got v=%b lvl=%0d, want v=0 lvl=0", m_valid, level);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        tests++;
        if (level !== LW'(3)) begin
            fails++;
            $display("FAIL flush_pre: got lvl=%0d, want 3", level);
        end
        cycle(1'b1, 32'hAA, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (level !== '0 || m_valid !== 1'b0 || s_ready !== 1'b1 || m_data === 32'hAA) begin
                fails++;
                $display("FAIL flush cyc%0d: got lvl=%0d v=%b r=%b d=%h, want lvl=0 v=0 r=1 d!=aa",
                         i, level, m_valid, s_ready, m_data);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        tests++;
        if (level !== LW'(2)) begin
            fails++;
            $display("FAIL async_pre: got lvl=%0d, want 2", level);
        end
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0 || level !== '0 || s_ready !== 1'b0 || m_data !== '0) begin
            fails++;
            $display("FAIL async_reset: got v=%b lvl=%0d r=%b d=%h, want v=0 lvl=0 r=0 d=0",
                     m_valid, level, s_ready, m_data);
        end
        q.delete();
        mdl_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b0, 1'b0);
        calc_exp();
        tests++;
        if (m_valid !== exp_v || s_ready !== exp_r || level !== exp_l || m_data !== exp_d) begin
            fails++;
            $display("FAIL async_recover: got v=%b r=%b lvl=%0d d=%h, want v=%b r=%b lvl=%0d d=%h",
                     m_valid, s_ready, level, m_data, exp_v, exp_r, exp_l, exp_d);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic             v;
        logic [WIDTH-1:0] d;
        logic             fl;
        v = 1'b0;
        d = '0;
        for (int i = 0; i < 400; i++) begin
            // Upstream holds a pending word until it is taken (or flushed).
            if (!v) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
            end
            fl = ($urandom_range(0, 31) == 0);
            if (v && (mdl_ready || fl)) begin
                cycle(1'b1, d, ($urandom_range(0, 2) != 0), fl);
                v = 1'b0;
            end else begin
                cycle(v, d, ($urandom_range(0, 2) != 0), fl);
            end
            calc_exp();
            tests++;
            if (m_valid !== exp_v || s_ready !== exp_r || level !== exp_l || m_data !== exp_d) begin
                fails++;
                $display("FAIL random cyc%0d: got v=%b r=%b lvl=%0d d=%h, want v=%b r=%b lvl=%0d d=%h",
                         i, m_valid, s_ready, level, m_data, exp_v, exp_r, exp_l, exp_d);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        mdl_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fall_through();
        test_fill_full();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
